// File: rtl/ff_chk_pkg.sv
// Shared types and helpers for the flip-flop response checker.
// State encoding, pipeline depth limit and saturating increment.
package ff_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    CHECK,
    HALT
  } chk_state_t;

  localparam int MAX_LAT = 8;
  localparam int FILL_W  = $clog2(MAX_LAT);

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] lim
  );
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ff_resp_checker_if.sv
// Stimulus/response bundle seen by the checker (master drives d/q).
// Optional capture signals exist only with FF_RESP_CHECKER_CAPTURE_EN.
interface ff_resp_checker_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);

  logic             start;
  logic             dut_rst;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] err_cnt;

`ifdef FF_RESP_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] first_exp;
  logic [WIDTH-1:0] first_act;
  logic [CNT_W-1:0] first_idx;

  modport master (
    output start, dut_rst, d, q,
    input  busy, done, err,
    input  pass_cnt, err_cnt,
    input  first_exp, first_act, first_idx
  );

  modport slave (
    input  start, dut_rst, d, q,
    output busy, done, err,
    output pass_cnt, err_cnt,
    output first_exp, first_act, first_idx
  );
`else
  modport master (
    output start, dut_rst, d, q,
    input  busy, done, err,
    input  pass_cnt, err_cnt
  );

  modport slave (
    input  start, dut_rst, d, q,
    output busy, done, err,
    output pass_cnt, err_cnt
  );
`endif

endinterface

// File: rtl/ff_chk_delay.sv
// WIDTH x LAT expected-value shift pipeline.
// Sync clear wins over shift; dout is the entry LAT stages back.
module ff_chk_delay #(
  parameter int WIDTH = 1,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [LAT];

  // shift register with async reset and sync clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= din;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[LAT-1];

endmodule

// File: rtl/ff_resp_checker.sv
// Compares delayed stimulus against flip-flop response, counts results.
// Define FF_RESP_CHECKER_CAPTURE_EN to record the first mismatch.
module ff_resp_checker
  import ff_chk_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int LAT         = 1,
  parameter int NUM_CHECKS  = 16,
  parameter int STOP_ON_ERR = 1,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst,
  ff_resp_checker_if.slave bus
);

  localparam int LAT_C =
    (LAT > MAX_LAT) ? MAX_LAT : ((LAT < 1) ? 1 : LAT);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(LAT_C - 1);
  localparam logic [CNT_W-1:0]  ONES      = '1;

  chk_state_t        state;
  logic [FILL_W-1:0] vcnt;
  logic [CNT_W-1:0]  cmp_cnt;
  logic [CNT_W-1:0]  pass_q;
  logic [CNT_W-1:0]  errc_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [WIDTH-1:0]  exp_in;
  logic [WIDTH-1:0]  exp_out;
  logic              shift;
  logic              hit;
  logic              last;
  logic              halt;

  assign exp_in = bus.dut_rst ? '0 : bus.d;
  assign shift  = (state == FILL || state == CHECK) && !bus.start;
  assign hit    = (exp_out == bus.q);
  assign last   = (NUM_CHECKS != 0) &&
                  (32'(cmp_cnt) + 32'd1 == 32'(NUM_CHECKS));
  assign halt   = last || (!hit && STOP_ON_ERR != 0);

  ff_chk_delay #(
    .WIDTH (WIDTH),
    .LAT   (LAT_C)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.start),
    .en   (shift),
    .din  (exp_in),
    .dout (exp_out)
  );

  // run control, counters and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vcnt    <= '0;
      cmp_cnt <= '0;
      pass_q  <= '0;
      errc_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.start) begin
      state   <= FILL;
      vcnt    <= '0;
      cmp_cnt <= '0;
      pass_q  <= '0;
      errc_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        FILL: begin
          if (vcnt == LAST_FILL) state <= CHECK;
          else vcnt <= vcnt + 1'b1;
        end
        CHECK: begin
          cmp_cnt <= CNT_W'(sat_inc(32'(cmp_cnt), 32'(ONES)));
          if (hit) begin
            pass_q <= CNT_W'(sat_inc(32'(pass_q), 32'(ONES)));
          end else begin
            errc_q <= CNT_W'(sat_inc(32'(errc_q), 32'(ONES)));
            err_q  <= 1'b1;
          end
          if (halt) begin
            state  <= HALT;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        HALT: ;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.pass_cnt = pass_q;
  assign bus.err_cnt  = errc_q;

`ifdef FF_RESP_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] fexp_q;
  logic [WIDTH-1:0] fact_q;
  logic [CNT_W-1:0] fidx_q;

  // latch expected/actual/index of the first mismatch in a run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fexp_q <= '0;
      fact_q <= '0;
      fidx_q <= '0;
    end else if (bus.start) begin
      fexp_q <= '0;
      fact_q <= '0;
      fidx_q <= '0;
    end else if (state == CHECK && !hit && !err_q) begin
      fexp_q <= exp_out;
      fact_q <= bus.q;
      fidx_q <= cmp_cnt;
    end
  end

  assign bus.first_exp = fexp_q;
  assign bus.first_act = fact_q;
  assign bus.first_idx = fidx_q;
`endif

endmodule

// File: tb/tb_ff_resp_checker.sv
// Randomized bench: three checker configs against a queue-based model.
// Ideal flip-flop DUT lives here; errors are injected by flipping q.
module tb_ff_resp_checker;

  localparam int N = 3;
  localparam int LATP  [N] = '{1, 3, 2};
  localparam int NCHK  [N] = '{16, 16, 0};
  localparam int STOPP [N] = '{1, 0, 0};
  localparam int CWP   [N] = '{16, 16, 3};

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_rst;
  logic [7:0] d;

  logic [7:0] dp [8];
  bit         inj [N];
  logic [7:0] qv [N];

  logic        busy_o [N];
  logic        done_o [N];
  logic        err_o  [N];
  logic [15:0] pc_o   [N];
  logic [15:0] ec_o   [N];

  int checks = 0;
  int errors = 0;

  bit         m_busy [N];
  bit         m_done [N];
  bit         m_err  [N];
  int         m_pass [N];
  int         m_errc [N];
  int         m_ncmp [N];
  logic [7:0] exq    [N][$];
  logic [7:0] m_fexp [N];
  logic [7:0] m_fact [N];
  int         m_fidx [N];

  always #5 clk = ~clk;

  ff_resp_checker_if #(.WIDTH(8), .CNT_W(16)) ba ();
  ff_resp_checker_if #(.WIDTH(8), .CNT_W(16)) bb ();
  ff_resp_checker_if #(.WIDTH(8), .CNT_W(3))  bc ();

  ff_resp_checker #(
    .WIDTH(8), .LAT(1), .NUM_CHECKS(16),
    .STOP_ON_ERR(1), .CNT_W(16)
  ) u_a (.clk(clk), .rst(rst), .bus(ba));

  ff_resp_checker #(
    .WIDTH(8), .LAT(3), .NUM_CHECKS(16),
    .STOP_ON_ERR(0), .CNT_W(16)
  ) u_b (.clk(clk), .rst(rst), .bus(bb));

  ff_resp_checker #(
    .WIDTH(8), .LAT(2), .NUM_CHECKS(0),
    .STOP_ON_ERR(0), .CNT_W(3)
  ) u_c (.clk(clk), .rst(rst), .bus(bc));

  // ideal flip-flop chain with synchronous reset
  always @(posedge clk) begin
    for (int j = 7; j > 0; j--) dp[j] <= dp[j-1];
    dp[0] <= dut_rst ? 8'h00 : d;
  end

  assign qv[0] = dp[0] ^ {8{inj[0]}};
  assign qv[1] = dp[2] ^ {8{inj[1]}};
  assign qv[2] = dp[1] ^ {8{inj[2]}};

  assign ba.start = start;   assign ba.dut_rst = dut_rst;
  assign ba.d     = d;       assign ba.q       = qv[0];
  assign bb.start = start;   assign bb.dut_rst = dut_rst;
  assign bb.d     = d;       assign bb.q       = qv[1];
  assign bc.start = start;   assign bc.dut_rst = dut_rst;
  assign bc.d     = d;       assign bc.q       = qv[2];

  assign busy_o[0] = ba.busy;  assign done_o[0] = ba.done;
  assign err_o[0]  = ba.err;   assign pc_o[0]   = ba.pass_cnt;
  assign ec_o[0]   = ba.err_cnt;
  assign busy_o[1] = bb.busy;  assign done_o[1] = bb.done;
  assign err_o[1]  = bb.err;   assign pc_o[1]   = bb.pass_cnt;
  assign ec_o[1]   = bb.err_cnt;
  assign busy_o[2] = bc.busy;  assign done_o[2] = bc.done;
  assign err_o[2]  = bc.err;   assign pc_o[2]   = 16'(bc.pass_cnt);
  assign ec_o[2]   = 16'(bc.err_cnt);

`ifdef FF_RESP_CHECKER_CAPTURE_EN
  logic [7:0]  fe_o [N];
  logic [7:0]  fa_o [N];
  logic [15:0] fi_o [N];
  assign fe_o[0] = ba.first_exp;  assign fa_o[0] = ba.first_act;
  assign fi_o[0] = ba.first_idx;
  assign fe_o[1] = bb.first_exp;  assign fa_o[1] = bb.first_act;
  assign fi_o[1] = bb.first_idx;
  assign fe_o[2] = bc.first_exp;  assign fa_o[2] = bc.first_act;
  assign fi_o[2] = 16'(bc.first_idx);
`endif

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] satv(input int v, input int k);
    int cmax;
    cmax = (1 << CWP[k]) - 1;
    return 32'((v > cmax) ? cmax : v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_busy[k] = 0; m_done[k] = 0; m_err[k] = 0;
      m_pass[k] = 0; m_errc[k] = 0; m_ncmp[k] = 0;
      m_fexp[k] = '0; m_fact[k] = '0; m_fidx[k] = 0;
      exq[k].delete();
    end
  endtask

  // one clock edge of every checker, from the rules of a run
  task automatic model_edge();
    logic [7:0] e;
    bit         miss;
    for (int k = 0; k < N; k++) begin
      if (start) begin
        model_clear(k);
        m_busy[k] = 1;
      end else if (m_busy[k]) begin
        if (exq[k].size() == LATP[k]) begin
          e = exq[k].pop_front();
          miss = (e != qv[k]);
          if (!miss) begin
            m_pass[k]++;
          end else begin
            if (!m_err[k]) begin
              m_fexp[k] = e;
              m_fact[k] = qv[k];
              m_fidx[k] = m_ncmp[k];
            end
            m_errc[k]++;
            m_err[k] = 1;
          end
          m_ncmp[k]++;
          if ((miss && STOPP[k] != 0) ||
              (NCHK[k] != 0 && m_ncmp[k] == NCHK[k])) begin
            m_busy[k] = 0;
            m_done[k] = 1;
          end
        end
        exq[k].push_back(dut_rst ? 8'h00 : d);
      end
    end
  endtask

  task automatic model_clear(input int k);
    m_done[k] = 0; m_err[k] = 0;
    m_pass[k] = 0; m_errc[k] = 0; m_ncmp[k] = 0;
    m_fexp[k] = '0; m_fact[k] = '0; m_fidx[k] = 0;
    exq[k].delete();
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("i%0d.busy", k), 32'(busy_o[k]), 32'(m_busy[k]));
      chk($sformatf("i%0d.done", k), 32'(done_o[k]), 32'(m_done[k]));
      chk($sformatf("i%0d.err", k), 32'(err_o[k]), 32'(m_err[k]));
      chk($sformatf("i%0d.pass", k), 32'(pc_o[k]), satv(m_pass[k], k));
      chk($sformatf("i%0d.errc", k), 32'(ec_o[k]), satv(m_errc[k], k));
`ifdef FF_RESP_CHECKER_CAPTURE_EN
      chk($sformatf("i%0d.fexp", k), 32'(fe_o[k]), 32'(m_fexp[k]));
      chk($sformatf("i%0d.fact", k), 32'(fa_o[k]), 32'(m_fact[k]));
      chk($sformatf("i%0d.fidx", k), 32'(fi_o[k]), satv(m_fidx[k], k));
`endif
    end
  endtask

  task automatic step(
    input bit          st,
    input logic [7:0]  dv,
    input bit          dr,
    input logic [31:0] injm
  );
    @(negedge clk);
    start   = st;
    d       = dv;
    dut_rst = dr;
    for (int k = 0; k < N; k++) begin
      inj[k] = !st && m_busy[k] &&
               exq[k].size() == LATP[k] &&
               m_ncmp[k] < 32 && injm[m_ncmp[k]];
    end
    #1;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // dmode: 0 alternate, 1 count, 2 random, 3 constant one
  task automatic run(
    input int          ncyc,
    input logic [31:0] injm,
    input int          dmode,
    input int          dr_lo,
    input int          dr_hi,
    input bit          dostart
  );
    logic [7:0] dv;
    for (int c = 0; c < ncyc; c++) begin
      unique case (dmode)
        0:       dv = 8'(c & 1);
        1:       dv = 8'(c - 1);
        2:       dv = 8'($urandom);
        default: dv = 8'h01;
      endcase
      step(dostart && c == 0, dv, c >= dr_lo && c <= dr_hi, injm);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dut_rst = 1'b0; d = 8'h00;
    for (int j = 0; j < 8; j++) dp[j] = 8'h00;
    for (int k = 0; k < N; k++) inj[k] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    run(24, 32'h0, 0, -1, -1, 1'b1);
    run(24, 32'h0000_0010, 2, -1, -1, 1'b1);
    run(24, 32'h0000_0884, 2, -1, -1, 1'b1);
    run(24, 32'h0, 3, 4, 6, 1'b1);

    run(9, 32'h0, 2, -1, -1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    run(24, 32'h0, 1, -1, -1, 1'b1);

    for (int it = 0; it < 8; it++) begin
      int lo;
      lo = int'($urandom_range(0, 20));
      run(int'($urandom_range(6, 30)), $urandom & $urandom, 2,
          lo, lo + int'($urandom_range(0, 4)), 1'b1);
    end
    run(4, 32'h0, 2, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
